// File: rtl/smult_pkg.sv
// Shared types for the FP16 scalar-vector multiplier writeback path.
// Beat helpers slice a buffered result into register-file writes.
package smult_pkg;

  localparam int VEC_W   = 256;
  localparam int LANE_W  = 16;
  localparam int LANES   = 16;
  localparam int BEAT_W  = 64;
  localparam int BEATS   = VEC_W / BEAT_W;
  localparam int ADDR_W  = 8;
  localparam int BEAT_IW = $clog2(BEATS);

  typedef logic [BEAT_IW-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  typedef struct packed {
    logic [VEC_W-1:0]  product;
    logic              V;
    logic [ADDR_W-1:0] dest_base;
  } wb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

  function automatic logic [BEAT_W-1:0] beat_data(
    input wb_entry_t e,
    input beat_idx_t k
  );
    return e.product[k*BEAT_W +: BEAT_W];
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(
    input wb_entry_t e,
    input beat_idx_t k
  );
    return e.dest_base + ADDR_W'(k);
  endfunction

endpackage

// File: rtl/smult_wb_serializer_if.sv
// Multiplier-result capture side plus register-file write port.
// slave = serializer view, master = producer/consumer view.
interface smult_wb_serializer_if;
  import smult_pkg::*;

  logic [LANES*LANE_W-1:0] product;
  logic                    V;
  logic                    done;
  logic [ADDR_W-1:0]       dest_base;
  logic                    full;
  logic                    drop_err;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [BEAT_W-1:0]       wr_data;
  logic                    wr_last;
  logic                    wr_ovf;
  logic                    ovf_sticky;

  modport slave (
    input  product, V, done, dest_base, wr_ready,
    output full, drop_err, wr_valid, wr_addr,
    output wr_data, wr_last, wr_ovf, ovf_sticky
  );

  modport master (
    output product, V, done, dest_base, wr_ready,
    input  full, drop_err, wr_valid, wr_addr,
    input  wr_data, wr_last, wr_ovf, ovf_sticky
  );

endinterface

// File: rtl/smult_wb_fifo.sv
// Circular result buffer; head stays put until its last beat pops.
// o_next exposes head+1 so back-to-back drains need no bubble.
module smult_wb_fifo
  import smult_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  wb_entry_t              i_data,
  output wb_entry_t              o_head,
  output wb_entry_t              o_next,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;

  assign o_head  = r_mem[r_head];
  assign o_next  = r_mem[r_head + PW'(1)];
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (i_pop) begin
        r_head <= r_head + PW'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/smult_wb_serializer.sv
// Writeback serializer: buffers multiplier results, drains 64-bit beats.
// Define SMULT_WB_OVF_STICKY_EN to keep a sticky overflow flag.
module smult_wb_serializer
  import smult_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                 Clk,
  input logic                 Rst,
  smult_wb_serializer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_e      r_state;
  logic              r_done_q;
  beat_idx_t         r_beat;
  logic              r_full;
  logic              r_drop_err;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [BEAT_W-1:0] r_wr_data;
  logic              r_wr_last;
  logic              r_wr_ovf;

  wb_entry_t         w_cap_entry;
  wb_entry_t         w_head;
  wb_entry_t         w_next;
  logic [CW-1:0]     w_count;
  logic              w_fifo_full;
  logic              w_empty;
  logic              w_cap;
  logic              w_pop;
  logic              w_push;
  beat_idx_t         w_nbeat;

  assign w_cap   = bus.done & ~r_done_q;
  assign w_pop   = r_wr_valid & bus.wr_ready & r_wr_last;
  // a full buffer still takes a capture when its head leaves this edge
  assign w_push  = w_cap & (~w_fifo_full | w_pop);
  assign w_nbeat = r_beat + 1'b1;

  assign w_cap_entry.product   = bus.product;
  assign w_cap_entry.V         = bus.V;
  assign w_cap_entry.dest_base = bus.dest_base;

  smult_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cap_entry),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_full  (w_fifo_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_done_q   <= 1'b0;
      r_beat     <= '0;
      r_full     <= 1'b0;
      r_drop_err <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_last  <= 1'b0;
      r_wr_ovf   <= 1'b0;
    end else begin
      r_done_q   <= bus.done;
      r_full     <= w_fifo_full;
      r_drop_err <= w_cap & w_fifo_full & ~w_pop;
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state    <= SEND;
            r_beat     <= '0;
            r_wr_valid <= 1'b1;
            r_wr_addr  <= beat_addr(w_head, '0);
            r_wr_data  <= beat_data(w_head, '0);
            r_wr_last  <= 1'b0;
            r_wr_ovf   <= w_head.V;
          end
        end
        SEND: begin
          if (bus.wr_ready) begin
            if (r_wr_last) begin
              if (w_count > CW'(1)) begin
                r_beat    <= '0;
                r_wr_addr <= beat_addr(w_next, '0);
                r_wr_data <= beat_data(w_next, '0);
                r_wr_last <= 1'b0;
                r_wr_ovf  <= w_next.V;
              end else begin
                r_state    <= IDLE;
                r_wr_valid <= 1'b0;
                r_wr_last  <= 1'b0;
              end
            end else begin
              r_beat    <= w_nbeat;
              r_wr_addr <= beat_addr(w_head, w_nbeat);
              r_wr_data <= beat_data(w_head, w_nbeat);
              r_wr_last <= (w_nbeat == LAST_BEAT);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SMULT_WB_OVF_STICKY_EN
  logic r_ovf_sticky;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_pop && r_wr_ovf) begin
      r_ovf_sticky <= 1'b1;
    end
  end

  assign bus.ovf_sticky = r_ovf_sticky;
`else
  assign bus.ovf_sticky = 1'b0;
`endif

  assign bus.full     = r_full;
  assign bus.drop_err = r_drop_err;
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.wr_last  = r_wr_last;
  assign bus.wr_ovf   = r_wr_ovf;

endmodule

// File: tb/tb_smult_wb_serializer.sv
// Bench for smult_wb_serializer: vector table, beat scoreboard,
// hand sequences for hold-off, overflow of the buffer and reset.
module tb_smult_wb_serializer;

  typedef struct {
    logic [15:0] lane;
    logic        v;
    logic [7:0]  base;
    logic [63:0] exp_word;
    logic [7:0]  exp_a0;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
    logic        last;
    logic        ovf;
  } beat_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  beat_t sb[$];
  vec_t  tv[4];
  logic [255:0] rp;
  logic [63:0]  rw[4];

  smult_wb_serializer_if bus();

  smult_wb_serializer dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic [7:0] a0,
                            input logic [63:0] w0, input logic [63:0] w1,
                            input logic [63:0] w2, input logic [63:0] w3,
                            input logic ovf);
    sb.push_back('{a0,          w0, 1'b0, ovf});
    sb.push_back('{a0 + 8'd1,   w1, 1'b0, ovf});
    sb.push_back('{a0 + 8'd2,   w2, 1'b0, ovf});
    sb.push_back('{a0 + 8'd3,   w3, 1'b1, ovf});
  endtask

  task automatic capture(input logic [255:0] p, input logic v,
                         input logic [7:0] base);
    bus.product   = p;
    bus.V         = v;
    bus.dest_base = base;
    bus.done      = 1'b1;
    tick();
    bus.done      = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.wr_valid) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: drain timeout, %0d beats pending want 0",
               nm, sb.size());
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.wr_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: wr_valid got 0 want 1 within 20 cycles", nm);
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (!rst && bus.wr_valid && bus.wr_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got addr %h data %h want none",
                 bus.wr_addr, bus.wr_data);
      end else begin
        b = sb.pop_front();
        chk("beat_addr", 64'(bus.wr_addr), 64'(b.addr));
        chk("beat_data", bus.wr_data, b.data);
        chk("beat_last", 64'(bus.wr_last), 64'(b.last));
        chk("beat_ovf", 64'(bus.wr_ovf), 64'(b.ovf));
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.product   = '0;
    bus.V         = 1'b0;
    bus.done      = 1'b0;
    bus.dest_base = '0;
    bus.wr_ready  = 1'b0;

    tv[0] = '{16'h3c00, 1'b0, 8'h10, 64'h3c003c003c003c00, 8'h10, 1'b0};
    tv[1] = '{16'h7c00, 1'b1, 8'hFE, 64'h7c007c007c007c00, 8'hFE, 1'b1};
    tv[2] = '{16'h0000, 1'b0, 8'h00, 64'h0000000000000000, 8'h00, 1'b0};
    tv[3] = '{16'hffff, 1'b1, 8'h7f, 64'hffffffffffffffff, 8'h7f, 1'b1};

    #12;
    chk("rst_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_drop", 64'(bus.drop_err), 64'd0);
    chk("rst_last", 64'(bus.wr_last), 64'd0);
    chk("rst_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_data", bus.wr_data, 64'd0);
    chk("rst_ovf", 64'(bus.wr_ovf), 64'd0);
    chk("rst_sticky", 64'(bus.ovf_sticky), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_valid", 64'(bus.wr_valid), 64'd0);

    // table vectors, ready always high
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_beats(tv[i].exp_a0, tv[i].exp_word, tv[i].exp_word,
                 tv[i].exp_word, tv[i].exp_word, tv[i].exp_ovf);
      capture({16{tv[i].lane}}, tv[i].v, tv[i].base);
      chk("latency_valid", 64'(bus.wr_valid), 64'd0);
      tick();
      chk("latency_valid", 64'(bus.wr_valid), 64'd1);
      wait_drain("table");
      tick();
    end
`ifdef SMULT_WB_OVF_STICKY_EN
    chk("ovf_sticky", 64'(bus.ovf_sticky), 64'd1);
`else
    chk("ovf_sticky", 64'(bus.ovf_sticky), 64'd0);
`endif

    // distinct lanes: beat order lanes 0-3 first
    for (int i = 0; i < 16; i++) rp[i*16 +: 16] = 16'h1100 + 16'(i);
    for (int k = 0; k < 4; k++)
      rw[k] = {16'h1100 + 16'(4*k+3), 16'h1100 + 16'(4*k+2),
               16'h1100 + 16'(4*k+1), 16'h1100 + 16'(4*k)};
    chk("ramp_model", rw[0], 64'h1103110211011100);
    push_beats(8'h40, rw[0], rw[1], rw[2], rw[3], 1'b0);
    capture(rp, 1'b0, 8'h40);
    wait_drain("ramp");

    // done held high: one capture only
    push_beats(8'h20, {4{16'h4000}}, {4{16'h4000}},
               {4{16'h4000}}, {4{16'h4000}}, 1'b0);
    bus.product   = {16{16'h4000}};
    bus.V         = 1'b0;
    bus.dest_base = 8'h20;
    bus.done      = 1'b1;
    repeat (10) tick();
    bus.done = 1'b0;
    wait_drain("held_done");
    repeat (6) tick();
    chk("held_idle", 64'(bus.wr_valid), 64'd0);

    // ready low on beat 1 for 5 cycles
    bus.wr_ready = 1'b0;
    push_beats(8'h30, {4{16'hbc00}}, {4{16'hbc00}},
               {4{16'hbc00}}, {4{16'hbc00}}, 1'b0);
    capture({16{16'hbc00}}, 1'b0, 8'h30);
    wait_valid("stall_start");
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(bus.wr_valid), 64'd1);
      chk("stall_addr", 64'(bus.wr_addr), 64'h31);
      chk("stall_data", bus.wr_data, 64'hbc00bc00bc00bc00);
      tick();
    end
    bus.wr_ready = 1'b1;
    wait_drain("stall");

    // buffer full, third capture dropped
    bus.wr_ready = 1'b0;
    push_beats(8'h50, {4{16'h3800}}, {4{16'h3800}},
               {4{16'h3800}}, {4{16'h3800}}, 1'b0);
    capture({16{16'h3800}}, 1'b0, 8'h50);
    repeat (2) tick();
    push_beats(8'h60, {4{16'h4200}}, {4{16'h4200}},
               {4{16'h4200}}, {4{16'h4200}}, 1'b1);
    capture({16{16'h4200}}, 1'b1, 8'h60);
    chk("drop_none", 64'(bus.drop_err), 64'd0);
    repeat (2) tick();
    chk("full_set", 64'(bus.full), 64'd1);
    capture({16{16'h4400}}, 1'b0, 8'h70);
    chk("drop_pulse", 64'(bus.drop_err), 64'd1);
    tick();
    chk("drop_clear", 64'(bus.drop_err), 64'd0);
    chk("full_hold", 64'(bus.full), 64'd1);
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("no_bubble", 64'(bus.wr_valid), 64'd1);
      tick();
    end
    chk("drained_valid", 64'(bus.wr_valid), 64'd0);
    wait_drain("full_drop");

    // reset during beat 2 with a full buffer
    bus.wr_ready = 1'b0;
    push_beats(8'h80, {4{16'h1234}}, {4{16'h1234}},
               {4{16'h1234}}, {4{16'h1234}}, 1'b0);
    capture({16{16'h1234}}, 1'b0, 8'h80);
    repeat (2) tick();
    capture({16{16'h5678}}, 1'b0, 8'h90);
    bus.wr_ready = 1'b1;
    tick();
    tick();
    bus.wr_ready = 1'b0;
    chk("pre_rst_addr", 64'(bus.wr_addr), 64'h82);
    chk("pre_rst_full", 64'(bus.full), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_mid_full", 64'(bus.full), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 64'(bus.wr_valid), 64'd0);
    bus.wr_ready = 1'b1;
    push_beats(8'hA0, {4{16'h0241}}, {4{16'h0241}},
               {4{16'h0241}}, {4{16'h0241}}, 1'b0);
    capture({16{16'h0241}}, 1'b0, 8'hA0);
    wait_drain("post_rst");

    repeat (5) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
